rv32i_decode_stage: RTL

Pipelined RV32I instruction-decode stage. It is the producer side of the ALU control interface: it turns a fetched 32-bit instruction into the ALU controls (alu_op, funct3, funct7_bit5, operand selects), the immediate, register indices and class flags.
- Fetch side: valid/ready handshake.
- Execute side: registered valid/ready outputs through a 2-entry skid buffer, giving full throughput under backpressure.

---
 rtl/rv32i_pkg.sv | 71 +++++++
 rtl/rv32i_decoder.sv | 138 +++++++++++++
 rtl/rv32i_decode_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU codes, operand selects and
// the decoded bundle carried from the decode stage to execute.
package rv32i_pkg;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   localparam logic [1:0] OPA_RS1  = 2'b00;
   localparam logic [1:0] OPA_PC   = 2'b01;
   localparam logic [1:0] OPA_ZERO = 2'b10;

   localparam logic OPB_RS2 = 1'b0;
   localparam logic OPB_IMM = 1'b1;

   // Everything execute needs from one instruction, minus the PC.
   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rd_we;
      logic [31:0] imm;
      logic [1:0]  op_a_sel;
      logic        op_b_sel;
      logic [3:0]  alu_op;
      logic [2:0]  funct3;
      logic        funct7_bit5;
      logic        is_branch;
      logic        is_jump;
      logic        is_load;
      logic        is_store;
      logic        illegal;
   } decode_t;

   function automatic logic [31:0] imm_i(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[31:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[31:25], inst[11:7]};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] inst);
      return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] inst);
      return {inst[31:12], 12'h000};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] inst);
      return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I instruction decoder. Illegal encodings produce a bundle
// with only the raw register fields, funct3 and the illegal flag set.
module rv32i_decoder
   import rv32i_pkg::*;
(
   input  logic [31:0] i_inst,
   output decode_t     o_dec
);

   logic [6:0] w_opcode;
   logic [2:0] w_f3;
   logic [6:0] w_f7;

   assign w_opcode = i_inst[6:0];
   assign w_f3     = i_inst[14:12];
   assign w_f7     = i_inst[31:25];

   // Opcode dispatch; each legal branch fills the controls it needs.
   always_comb begin
      o_dec        = '0;
      o_dec.rs1    = i_inst[19:15];
      o_dec.rs2    = i_inst[24:20];
      o_dec.rd     = i_inst[11:7];
      o_dec.funct3 = w_f3;
      // The 7-bit opcode match also rejects inst[1:0] != 2'b11.
      case (w_opcode)
         OPC_OP: begin
            if (w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
               o_dec.alu_op      = {1'b0, w_f3};
               o_dec.funct7_bit5 = i_inst[30];
               o_dec.op_a_sel    = OPA_RS1;
               o_dec.op_b_sel    = OPB_RS2;
               o_dec.rd_we       = 1'b1;
            end else begin
               o_dec.illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            if ((w_f3 == 3'b001 && w_f7 != 7'h00) ||
                (w_f3 == 3'b101 && w_f7 != 7'h00 && w_f7 != 7'h20)) begin
               o_dec.illegal = 1'b1;
            end else begin
               o_dec.alu_op      = {1'b0, w_f3};
               // Only SRAI uses inst[30]; ADDI with a negative immediate stays ADD.
               o_dec.funct7_bit5 = (w_f3 == 3'b101) ? i_inst[30] : 1'b0;
               o_dec.imm         = imm_i(i_inst);
               o_dec.op_b_sel    = OPB_IMM;
               o_dec.rd_we       = 1'b1;
            end
         end
         OPC_LUI: begin
            o_dec.op_a_sel = OPA_ZERO;
            o_dec.op_b_sel = OPB_IMM;
            o_dec.imm      = imm_u(i_inst);
            o_dec.alu_op   = ALU_ADD;
            o_dec.rd_we    = 1'b1;
         end
         OPC_AUIPC: begin
            o_dec.op_a_sel = OPA_PC;
            o_dec.op_b_sel = OPB_IMM;
            o_dec.imm      = imm_u(i_inst);
            o_dec.alu_op   = ALU_ADD;
            o_dec.rd_we    = 1'b1;
         end
         OPC_JAL: begin
            o_dec.op_a_sel = OPA_PC;
            o_dec.op_b_sel = OPB_IMM;
            o_dec.imm      = imm_j(i_inst);
            o_dec.alu_op   = ALU_ADD;
            o_dec.is_jump  = 1'b1;
            o_dec.rd_we    = 1'b1;
         end
         OPC_JALR: begin
            if (w_f3 == 3'b000) begin
               o_dec.op_a_sel = OPA_RS1;
               o_dec.op_b_sel = OPB_IMM;
               o_dec.imm      = imm_i(i_inst);
               o_dec.alu_op   = ALU_ADD;
               o_dec.is_jump  = 1'b1;
               o_dec.rd_we    = 1'b1;
            end else begin
               o_dec.illegal = 1'b1;
            end
         end
         OPC_BRANCH: begin
            if (w_f3 == 3'b010 || w_f3 == 3'b011) begin
               o_dec.illegal = 1'b1;
            end else begin
               o_dec.op_a_sel  = OPA_RS1;
               o_dec.op_b_sel  = OPB_RS2;
               o_dec.imm       = imm_b(i_inst);
               o_dec.is_branch = 1'b1;
               if (w_f3[2] == 1'b0) begin
                  // BEQ/BNE compare via SUB and the zero flag.
                  o_dec.alu_op      = ALU_ADD;
                  o_dec.funct7_bit5 = 1'b1;
               end else if (w_f3[1] == 1'b0) begin
                  o_dec.alu_op = ALU_SLT;
               end else begin
                  o_dec.alu_op = ALU_SLTU;
               end
            end
         end
         OPC_LOAD: begin
            if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) begin
               o_dec.illegal = 1'b1;
            end else begin
               o_dec.op_a_sel = OPA_RS1;
               o_dec.op_b_sel = OPB_IMM;
               o_dec.imm      = imm_i(i_inst);
               o_dec.alu_op   = ALU_ADD;
               o_dec.is_load  = 1'b1;
               o_dec.rd_we    = 1'b1;
            end
         end
         OPC_STORE: begin
            if (w_f3 > 3'b010) begin
               o_dec.illegal = 1'b1;
            end else begin
               o_dec.op_a_sel = OPA_RS1;
               o_dec.op_b_sel = OPB_IMM;
               o_dec.imm      = imm_s(i_inst);
               o_dec.alu_op   = ALU_ADD;
               o_dec.is_store = 1'b1;
            end
         end
         OPC_MISC_MEM: begin
            // FENCE is a legal no-op in this pipeline.
         end
         default: begin
            o_dec.illegal = 1'b1;
         end
      endcase
      // x0 is never written.
      if (o_dec.rd == 5'd0) o_dec.rd_we = 1'b0;
   end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode pipeline stage: decodes the fetched instruction and registers
// the bundle behind a valid/ready output with an optional 2-entry skid buffer.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; a producer holds valid and payload stable until that edge, and ready
// carries no dependency on the same-cycle valid (with SKID_EN=1 it is a flop).
module rv32i_decode_stage
   import rv32i_pkg::*;
#(
   parameter bit SKID_EN = 1'b1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [4:0]  out_rd,
   output logic        out_rd_we,
   output logic [31:0] out_imm,
   output logic [1:0]  out_op_a_sel,
   output logic        out_op_b_sel,
   output logic [3:0]  out_alu_op,
   output logic [2:0]  out_funct3,
   output logic        out_funct7_bit5,
   output logic        out_is_branch,
   output logic        out_is_jump,
   output logic        out_is_load,
   output logic        out_is_store,
   output logic        out_illegal
);

   decode_t     w_dec;
   logic        w_in_ready;
   logic        w_accept;
   logic        w_drain;

   logic        r_main_valid;
   decode_t     r_main;
   logic [31:0] r_main_pc;
   logic        r_skid_valid;
   decode_t     r_skid;
   logic [31:0] r_skid_pc;

   rv32i_decoder u_decoder (
      .i_inst (in_inst),
      .o_dec  (w_dec)
   );

   assign w_in_ready = SKID_EN ? !r_skid_valid : (!r_main_valid || out_ready);
   assign w_accept   = in_valid && w_in_ready;
   assign w_drain    = r_main_valid && out_ready;

   // Main/skid pipeline registers: refill main from skid first to keep order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_valid <= 1'b0;
         r_main       <= '0;
         r_main_pc    <= '0;
         r_skid_valid <= 1'b0;
         r_skid       <= '0;
         r_skid_pc    <= '0;
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (!r_main_valid || w_drain) begin
         if (r_skid_valid) begin
            r_main       <= r_skid;
            r_main_pc    <= r_skid_pc;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
         end else if (w_accept) begin
            r_main       <= w_dec;
            r_main_pc    <= in_pc;
            r_main_valid <= 1'b1;
         end else begin
            r_main_valid <= 1'b0;
         end
      end else if (w_accept) begin
         // Main is stalled: park the new bundle in the skid entry.
         r_skid       <= w_dec;
         r_skid_pc    <= in_pc;
         r_skid_valid <= 1'b1;
      end
   end

   assign in_ready        = w_in_ready;
   assign out_valid       = r_main_valid;
   assign out_pc          = r_main_pc;
   assign out_rs1         = r_main.rs1;
   assign out_rs2         = r_main.rs2;
   assign out_rd          = r_main.rd;
   assign out_rd_we       = r_main.rd_we;
   assign out_imm         = r_main.imm;
   assign out_op_a_sel    = r_main.op_a_sel;
   assign out_op_b_sel    = r_main.op_b_sel;
   assign out_alu_op      = r_main.alu_op;
   assign out_funct3      = r_main.funct3;
   assign out_funct7_bit5 = r_main.funct7_bit5;
   assign out_is_branch   = r_main.is_branch;
   assign out_is_jump     = r_main.is_jump;
   assign out_is_load     = r_main.is_load;
   assign out_is_store    = r_main.is_store;
   assign out_illegal     = r_main.illegal;

endmodule
